// File: rtl/input_conditioner_pkg.sv
// Shared types and constants for the two-channel pushbutton/switch conditioner.
// The debounce FSM state encoding lives here so the channel and the bench agree on it.
package input_conditioner_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 250000;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } db_state_e;

  // The accepted level is 1 while high is stable or while a fall is still unproven.
  function automatic logic level_of(db_state_e st);
    return (st == STABLE_HI) || (st == CHECK_LO);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Raw switch inputs and conditioned outputs of the light-control input stage.
// master drives the raw inputs, slave (the conditioner) drives levels and pulses.
interface input_conditioner_if;

  logic i_raw;
  logic s_raw;
  logic i;
  logic s;
  logic i_rise;
  logic s_rise;

  modport master (
    output i_raw,
    output s_raw,
    input  i,
    input  s,
    input  i_rise,
    input  s_rise
  );

  modport slave (
    input  i_raw,
    input  s_raw,
    output i,
    output s,
    output i_rise,
    output s_rise
  );

endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchronizer, 4-state debounce FSM with a
// saturating stability counter, registered level and one-cycle rise pulse.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  // Counter value at which the next stable cycle completes the debounce window.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic      meta;
  logic      synced;
  db_state_e state;
  db_state_e state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic      level_q;
  logic      level_nxt;
  logic      rise_q;
  logic      rise_nxt;

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, which the two synchronizer stages rely on.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= STABLE_LO;
      cnt     <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      level_q <= level_nxt;
      rise_q  <= rise_nxt;
    end
  end

  // NOTE: defaults at the top of the block keep every path assigned, so no
  // latch is inferred for state_nxt or cnt_nxt.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      STABLE_LO: begin
        cnt_nxt = '0;
        if (synced) state_nxt = CHECK_HI;
      end
      CHECK_HI: begin
        if (!synced) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STABLE_HI: begin
        cnt_nxt = '0;
        if (!synced) state_nxt = CHECK_LO;
      end
      CHECK_LO: begin
        if (synced) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = STABLE_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state, so they change on the same
  // edge as the FSM and have no path back to the raw input.
  always_comb begin
    level_nxt = level_of(state_nxt);
    rise_nxt  = level_nxt & ~level_q;
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the asynchronous i and s switch inputs for the light-control FSM:
// two identical, independent debounce channels.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input logic            Clock,
  input logic            Reset,
  input_conditioner_if.slave bus
);

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ch_i (
    .Clock (Clock),
    .Reset (Reset),
    .raw   (bus.i_raw),
    .level (bus.i),
    .rise  (bus.i_rise)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ch_s (
    .Clock (Clock),
    .Reset (Reset),
    .raw   (bus.s_raw),
    .level (bus.s),
    .rise  (bus.s_rise)
  );

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4: directed scenarios plus a
// randomized run, all compared against a sample-history debounce model.
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int D = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  input_conditioner_if bus ();

  input_conditioner #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Model: the FSM sees each raw sample two edges late; a level flips once the
  // seen value has differed from it on D consecutive edges.
  logic [1:0] hist[$];
  int         m_run[2];
  logic [1:0] m_lvl  = 2'b00;
  logic [1:0] m_rise = 2'b00;

  task automatic tick();
    logic [1:0] v;
    @(posedge Clock);
    if (Reset) begin
      hist   = {2'b00, 2'b00};
      m_run  = '{0, 0};
      m_lvl  = 2'b00;
      m_rise = 2'b00;
    end else begin
      hist.push_back({bus.s_raw, bus.i_raw});
      v = hist.pop_front();
      for (int c = 0; c < 2; c++) begin
        m_rise[c] = 1'b0;
        if (v[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_lvl[c]  = ~m_lvl[c];
            m_run[c]  = 0;
            m_rise[c] = m_lvl[c];
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end
    @(negedge Clock);
  endtask

  task automatic test_reset();
    bit found = 0;
    bus.i_raw = 1'b1;
    bus.s_raw = 1'b1;
    Reset = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if ({bus.s_rise, bus.i_rise, bus.s, bus.i} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold: {s_rise,i_rise,s,i}=%b, expected 0000",
                 {bus.s_rise, bus.i_rise, bus.s, bus.i});
      end
    end
    Reset = 1'b0;
    for (int n = 1; n <= 20 && !found; n++) begin
      tick();
      checks++;
      if ({bus.s_rise, bus.i_rise, bus.s, bus.i} !== {m_rise, m_lvl}) begin
        errors++;
        $display("FAIL model_reset_release: got %b, expected %b",
                 {bus.s_rise, bus.i_rise, bus.s, bus.i}, {m_rise, m_lvl});
      end
      if (bus.i === 1'b1) begin
        found = 1;
        checks++;
        if (n != D + 2) begin
          errors++;
          $display("FAIL reset_release_latency: i rose after %0d edges, expected %0d", n, D + 2);
        end
        checks++;
        if ({bus.i_rise, bus.s_rise} !== 2'b11) begin
          errors++;
          $display("FAIL reset_release_pulse: {i_rise,s_rise}=%b, expected 11",
                   {bus.i_rise, bus.s_rise});
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_release_timeout: i still %b after 20 edges, expected 1", bus.i);
    end
    tick();
    checks++;
    if ({bus.i_rise, bus.s_rise, bus.i} !== 3'b001) begin
      errors++;
      $display("FAIL reset_pulse_width: {i_rise,s_rise,i}=%b, expected 001",
               {bus.i_rise, bus.s_rise, bus.i});
    end
  endtask

  task automatic test_latency();
    int fall_at = 0;
    int rise_at = 0;
    int pulses  = 0;
    bus.i_raw = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++;
      if ({bus.s_rise, bus.i_rise, bus.s, bus.i} !== {m_rise, m_lvl}) begin
        errors++;
        $display("FAIL model_fall: got %b, expected %b",
                 {bus.s_rise, bus.i_rise, bus.s, bus.i}, {m_rise, m_lvl});
      end
      if (bus.i_rise === 1'b1) pulses++;
      if (bus.i === 1'b0 && fall_at == 0) fall_at = n;
    end
    checks++;
    if (fall_at != D + 2 || pulses != 0) begin
      errors++;
      $display("FAIL fall_latency: fell at edge %0d with %0d pulses, expected edge %0d with 0",
               fall_at, pulses, D + 2);
    end
    bus.i_raw = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++;
      if ({bus.s_rise, bus.i_rise, bus.s, bus.i} !== {m_rise, m_lvl}) begin
        errors++;
        $display("FAIL model_rise: got %b, expected %b",
                 {bus.s_rise, bus.i_rise, bus.s, bus.i}, {m_rise, m_lvl});
      end
      if (bus.i_rise === 1'b1) pulses++;
      if (bus.i === 1'b1 && rise_at == 0) begin
        rise_at = n;
        checks++;
        if (bus.i_rise !== 1'b1) begin
          errors++;
          $display("FAIL rise_pulse_align: i_rise=%b on first high cycle, expected 1", bus.i_rise);
        end
      end
    end
    checks++;
    if (rise_at != D + 2 || pulses != 1) begin
      errors++;
      $display("FAIL rise_latency: rose at edge %0d with %0d pulses, expected edge %0d with 1",
               rise_at, pulses, D + 2);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    int highs  = 0;
    bus.i_raw = 1'b0;
    bus.s_raw = 1'b0;
    repeat (10) tick();
    for (int n = 0; n < 14; n++) begin
      bus.i_raw = (n < D - 1);
      tick();
      checks++;
      if ({bus.s_rise, bus.i_rise, bus.s, bus.i} !== {m_rise, m_lvl}) begin
        errors++;
        $display("FAIL model_glitch: got %b, expected %b",
                 {bus.s_rise, bus.i_rise, bus.s, bus.i}, {m_rise, m_lvl});
      end
      if (bus.i_rise === 1'b1) pulses++;
      if (bus.i === 1'b1) highs++;
    end
    checks++;
    if (pulses != 0 || highs != 0) begin
      errors++;
      $display("FAIL glitch_reject: %0d pulses, %0d high cycles, expected 0 and 0", pulses, highs);
    end
    checks++;
    if (dut.u_ch_i.state !== STABLE_LO) begin
      errors++;
      $display("FAIL glitch_state: state=%0d, expected %0d", dut.u_ch_i.state, STABLE_LO);
    end
  endtask

  task automatic test_bounce();
    logic [9:0] pattern = 10'b1111101101;  // bit n is applied on cycle n
    int pulses   = 0;
    int first_hi = -1;
    for (int n = 0; n < 20; n++) begin
      bus.i_raw = (n < 10) ? pattern[n] : 1'b1;
      tick();
      checks++;
      if ({bus.s_rise, bus.i_rise, bus.s, bus.i} !== {m_rise, m_lvl}) begin
        errors++;
        $display("FAIL model_bounce: got %b, expected %b",
                 {bus.s_rise, bus.i_rise, bus.s, bus.i}, {m_rise, m_lvl});
      end
      if (bus.i_rise === 1'b1) pulses++;
      if (bus.i === 1'b1 && first_hi < 0) first_hi = n;
    end
    checks++;
    if (pulses != 1 || first_hi != 5 + 1 + D) begin
      errors++;
      $display("FAIL bounce_accept: %0d pulses, first high cycle %0d, expected 1 and %0d",
               pulses, first_hi, 5 + 1 + D);
    end
  endtask

  task automatic test_simultaneous();
    bit found = 0;
    bus.i_raw = 1'b0;
    bus.s_raw = 1'b0;
    repeat (10) tick();
    bus.i_raw = 1'b1;
    bus.s_raw = 1'b1;
    for (int n = 1; n <= 20 && !found; n++) begin
      tick();
      checks++;
      if ({bus.s_rise, bus.i_rise, bus.s, bus.i} !== {m_rise, m_lvl}) begin
        errors++;
        $display("FAIL model_simultaneous: got %b, expected %b",
                 {bus.s_rise, bus.i_rise, bus.s, bus.i}, {m_rise, m_lvl});
      end
      if (bus.i === 1'b1 || bus.s === 1'b1) begin
        found = 1;
        checks++;
        if ({bus.s_rise, bus.i_rise, bus.s, bus.i} !== 4'b1111 || n != D + 2) begin
          errors++;
          $display("FAIL simultaneous_accept: {s_rise,i_rise,s,i}=%b at edge %0d, expected 1111 at %0d",
                   {bus.s_rise, bus.i_rise, bus.s, bus.i}, n, D + 2);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL simultaneous_timeout: no level change within 20 edges, expected one");
    end
  endtask

  task automatic test_reset_mid_check();
    int rise_at = 0;
    int pulses  = 0;
    bus.i_raw = 1'b0;
    bus.s_raw = 1'b0;
    repeat (10) tick();
    bus.i_raw = 1'b1;
    repeat (4) tick();
    checks++;
    if (dut.u_ch_i.state !== CHECK_HI || bus.i !== 1'b0) begin
      errors++;
      $display("FAIL mid_check_setup: state=%0d i=%b, expected %0d and 0",
               dut.u_ch_i.state, bus.i, CHECK_HI);
    end
    Reset = 1'b1;
    repeat (2) begin
      tick();
      checks++;
      if ({bus.s_rise, bus.i_rise, bus.s, bus.i} !== 4'b0000) begin
        errors++;
        $display("FAIL mid_check_reset: {s_rise,i_rise,s,i}=%b, expected 0000",
                 {bus.s_rise, bus.i_rise, bus.s, bus.i});
      end
    end
    Reset = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++;
      if ({bus.s_rise, bus.i_rise, bus.s, bus.i} !== {m_rise, m_lvl}) begin
        errors++;
        $display("FAIL model_mid_check: got %b, expected %b",
                 {bus.s_rise, bus.i_rise, bus.s, bus.i}, {m_rise, m_lvl});
      end
      if (bus.i_rise === 1'b1) pulses++;
      if (bus.i === 1'b1 && rise_at == 0) rise_at = n;
    end
    checks++;
    if (rise_at != D + 2 || pulses != 1) begin
      errors++;
      $display("FAIL mid_check_restart: rose at edge %0d with %0d pulses, expected edge %0d with 1",
               rise_at, pulses, D + 2);
    end
  endtask

  task automatic test_random();
    int accepted = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) bus.i_raw = ~bus.i_raw;
      if ($urandom_range(0, 5) == 0) bus.s_raw = ~bus.s_raw;
      Reset = ($urandom_range(0, 499) == 0);
      tick();
      checks++;
      if ({bus.s_rise, bus.i_rise, bus.s, bus.i} !== {m_rise, m_lvl}) begin
        errors++;
        $display("FAIL model_random cycle %0d: got %b, expected %b",
                 n, {bus.s_rise, bus.i_rise, bus.s, bus.i}, {m_rise, m_lvl});
      end
      if (m_rise != 2'b00) accepted++;
    end
    Reset = 1'b0;
    checks++;
    if (accepted == 0) begin
      errors++;
      $display("FAIL random_activity: model saw %0d accepted rises, expected some", accepted);
    end
  endtask

  initial begin
    bus.i_raw = 1'b0;
    bus.s_raw = 1'b0;
    @(negedge Clock);
    test_reset();
    test_latency();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid_check();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

endmodule
